btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce_pkg.sv | 12 +
 rtl/btn_debounce_cell.sv | 112 +++++++++++
 rtl/btn_debounce.sv | 38 +++
 tb/tb_btn_debounce.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the button debouncer.
package btn_debounce_pkg;
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } db_state_e;

  localparam int CNT_W              = 4;
  localparam int DEF_STABLE_SAMPLES = 3;
endpackage

// File: rtl/btn_debounce_cell.sv
// One debounce channel: 2-flop synchronizer, qualification FSM and registered outputs.
module btn_debounce_cell
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic stb,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic rel
);
  localparam logic [CNT_W-1:0] SS_C = CNT_W'(STABLE_SAMPLES);

  logic             sync1_q, sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d, press_q, press_d, rel_q, rel_d;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // Pulses default low, so they last exactly the one cycle after a qualifying strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (stb) begin
      case (state_q)
        ST_IDLE: begin
          if (sync2_q) begin
            state_d = ST_PRESS_PEND;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ST_PRESS_PEND: begin
          if (!sync2_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == SS_C) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!sync2_q) begin
            state_d = ST_RELEASE_PEND;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ST_RELEASE_PEND: begin
          if (sync2_q) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == SS_C) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
endmodule

// File: rtl/btn_debounce.sv
// N-channel button debouncer; one shared sample strobe from the rising edge of in_slow_clk.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_slow_clk,
  input  logic [N_BTN-1:0] in_btn,
  output logic [N_BTN-1:0] out_level,
  output logic [N_BTN-1:0] out_press,
  output logic [N_BTN-1:0] out_release
);
  logic slow_d_q;
  logic stb;

  // in_slow_clk is sampled as data; slow_d_q resets low so a high level right after reset yields one strobe.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) slow_d_q <= 1'b0;
    else           slow_d_q <= in_slow_clk;
  end

  assign stb = in_slow_clk & ~slow_d_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_debounce_cell #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_cell (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .stb      (stb),
      .btn_raw  (in_btn[i]),
      .level    (out_level[i]),
      .press    (out_press[i]),
      .rel      (out_release[i])
    );
  end
endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench: expected pulse events are queued when stimulus is driven and popped when the DUT pulses.
module tb_btn_debounce;
  logic       in_clk = 1'b0;
  logic       in_rst_n;
  logic       in_slow_clk = 1'b0;
  logic [3:0] in_btn;
  logic [3:0] out_level, out_press, out_release;

  typedef struct {
    int         stb;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
  } ev_t;

  ev_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stb_cnt = 0;
  logic slow_prev = 1'b0;
  bit   slow_run = 1'b1;

  btn_debounce #(.N_BTN(4), .STABLE_SAMPLES(3)) dut (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .in_slow_clk (in_slow_clk),
    .in_btn      (in_btn),
    .out_level   (out_level),
    .out_press   (out_press),
    .out_release (out_release)
  );

  always #5 in_clk = ~in_clk;

  // Divided clock: toggles every 4 in_clk cycles, just after the rising edge.
  initial begin
    forever begin
      repeat (4) @(posedge in_clk);
      #1;
      if (slow_run) in_slow_clk = ~in_slow_clk;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs reflect the strobe counted on the previous negedge, so compare before counting.
  always @(negedge in_clk) begin
    ev_t e;
    if ((out_press | out_release) !== 4'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {24'b0, out_press, out_release}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("pulse_strobe", stb_cnt, e.stb);
        chk("pulse_press", {28'b0, out_press}, {28'b0, e.press});
        chk("pulse_release", {28'b0, out_release}, {28'b0, e.rel});
        chk("pulse_level", {28'b0, out_level}, {28'b0, e.level});
      end
    end
    if (!in_rst_n) begin
      slow_prev = 1'b0;
    end else begin
      if (in_slow_clk && !slow_prev) stb_cnt++;
      slow_prev = in_slow_clk;
    end
  end

  // Returns just after the clock edge that ends the n-th strobe cycle from now.
  task automatic wait_stb(input int n);
    int target = stb_cnt + n;
    int guard  = 0;
    while (stb_cnt < target && guard < n * 8 + 40) begin
      @(negedge in_clk);
      #1;
      guard++;
    end
    if (stb_cnt < target) chk("strobe_timeout", stb_cnt, target);
    @(posedge in_clk);
    #1;
  endtask

  task automatic push(input int s, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.stb = s; e.press = p; e.rel = r; e.level = l;
    sb.push_back(e);
  endtask

  initial begin
    in_rst_n = 1'b0;
    in_btn   = 4'b0000;
    repeat (3) @(negedge in_clk);
    chk("rst_level", {28'b0, out_level}, 32'h0);
    chk("rst_press", {28'b0, out_press}, 32'h0);
    chk("rst_release", {28'b0, out_release}, 32'h0);
    @(posedge in_clk);
    #1 in_rst_n = 1'b1;

    // Idle buttons across 10 strobes: nothing may move.
    wait_stb(10);
    chk("idle_level", {28'b0, out_level}, 32'h0);

    // Clean press on button 0: accepted on the 3rd strobe after sync.
    wait_stb(1);
    in_btn[0] = 1'b1;
    push(stb_cnt + 3, 4'b0001, 4'b0000, 4'b0001);
    wait_stb(4);
    chk("press0_level", {28'b0, out_level}, 32'h1);

    // Bouncing button 1 never reaches 3 agreeing strobes.
    wait_stb(1);
    in_btn[1] = 1'b1;
    wait_stb(1);
    in_btn[1] = 1'b0;
    wait_stb(1);
    in_btn[1] = 1'b1;
    wait_stb(2);
    in_btn[1] = 1'b0;
    wait_stb(3);
    chk("bounce1_level", {28'b0, out_level}, 32'h1);

    // Buttons 2 and 3 together: simultaneous press then simultaneous release.
    wait_stb(1);
    in_btn[3:2] = 2'b11;
    push(stb_cnt + 3, 4'b1100, 4'b0000, 4'b1101);
    wait_stb(4);
    chk("press23_level", {28'b0, out_level}, 32'hd);
    in_btn[3:2] = 2'b00;
    push(stb_cnt + 3, 4'b0000, 4'b1100, 4'b0001);
    wait_stb(4);
    chk("release23_level", {28'b0, out_level}, 32'h1);

    // Mid-operation reset with button 0 held: async clear, then re-qualify.
    wait_stb(1);
    in_rst_n = 1'b0;
    #2;
    chk("async_rst_level", {28'b0, out_level}, 32'h0);
    chk("async_rst_press", {28'b0, out_press}, 32'h0);
    chk("async_rst_release", {28'b0, out_release}, 32'h0);
    repeat (4) @(posedge in_clk);
    #1 in_rst_n = 1'b1;
    push(stb_cnt + 3, 4'b0001, 4'b0000, 4'b0001);
    wait_stb(4);
    chk("requal0_level", {28'b0, out_level}, 32'h1);

    // Slow clock stuck high: the single post-reset strobe sees idle buttons, then nothing changes.
    @(posedge in_clk);
    #3;
    slow_run    = 1'b0;
    in_slow_clk = 1'b1;
    in_rst_n    = 1'b0;
    in_btn      = 4'b0000;
    repeat (3) @(posedge in_clk);
    #1 in_rst_n = 1'b1;
    repeat (4) @(posedge in_clk);
    for (int i = 0; i < 16; i++) begin
      repeat (3) @(posedge in_clk);
      #1 in_btn = 4'($urandom_range(0, 15));
    end
    in_btn = 4'b1111;
    repeat (40) @(posedge in_clk);
    @(negedge in_clk);
    chk("stuck_level", {28'b0, out_level}, 32'h0);
    chk("queue_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
